// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receive half of the UART peripheral. Recovers 8N1 frames (start 0, eight
//   data bits LSB first, stop 1, idle high) from the asynchronous rx line and
//   hands complete bytes to the register/FIFO layer via a flag/acknowledge
//   handshake.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst            synchronous active-high reset
//   cyclesPerBit   bit period C in clk cycles (C >= 4), change only while idle
//   rx             asynchronous serial input, idle high
//   dataOut        last correctly framed byte, held until the next delivery
//   dataAvailable  a byte is waiting in dataOut
//   dataRead       consumer acknowledge, clears dataAvailable
//   framingError   sticky, stop bit sampled low
//   overrun        sticky, byte delivered while the previous one was unread
//   clearErrors    clears framingError and overrun
//   busy           high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_SCALE_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic                        rx,
    output logic [7:0]                  dataOut,
    output logic                        dataAvailable,
    input  logic                        dataRead,
    output logic                        framingError,
    output logic                        overrun,
    input  logic                        clearErrors,
    output logic                        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                      state_q;
    logic                        rx_meta_q;
    logic                        rx_sync_q;
    logic [CLOCK_SCALE_BITS-1:0] cnt_q;
    logic [2:0]                  bit_q;
    logic [7:0]                  shift_q;
    logic [7:0]                  data_out_q;
    logic                        data_avail_q;
    logic                        framing_err_q;
    logic                        overrun_q;
    logic                        busy_q;

    logic [CLOCK_SCALE_BITS-1:0] cnt_next_s;
    logic [CLOCK_SCALE_BITS-1:0] half_s;

    assign cnt_next_s = cnt_q + CLOCK_SCALE_BITS'(1);
    assign half_s     = cyclesPerBit >> 1;

    assign dataOut       = data_out_q;
    assign dataAvailable = data_avail_q;
    assign framingError  = framing_err_q;
    assign overrun       = overrun_q;
    assign busy          = busy_q;

    // Two-flop synchronizer for the asynchronous rx pin; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM plus the consumer handshake and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_q         <= 3'd0;
            shift_q       <= 8'h00;
            data_out_q    <= 8'h00;
            data_avail_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Clears are applied first so that a delivery or error set in the
            // same cycle (written later in this block) takes precedence.
            if (dataRead) begin
                data_avail_q <= 1'b0;
            end
            if (clearErrors) begin
                framing_err_q <= 1'b0;
                overrun_q     <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= 3'd0;
                    if (!rx_sync_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                // Re-check the start bit half a period in; a high line here is
                // a glitch and is dropped silently.
                S_START: begin
                    if (cnt_next_s == half_s) begin
                        cnt_q <= '0;
                        if (!rx_sync_q) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_next_s;
                    end
                end

                // From the mid-start reference, every C cycles lands mid-bit.
                S_DATA: begin
                    if (cnt_next_s == cyclesPerBit) begin
                        shift_q[bit_q] <= rx_sync_q;
                        cnt_q          <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_next_s;
                    end
                end

                // Delivery happens mid stop bit, so a following start edge
                // with no idle gap is still caught from IDLE.
                S_STOP: begin
                    if (cnt_next_s == cyclesPerBit) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            data_out_q   <= shift_q;
                            data_avail_q <= 1'b1;
                            if (data_avail_q && !dataRead) begin
                                overrun_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            framing_err_q <= 1'b1;
                            state_q       <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_next_s;
                    end
                end

                // Hold off until the line is released so a break condition
                // does not look like a stream of new start bits.
                S_BREAK: begin
                    if (rx_sync_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cyclesPerBit;
    logic        rx;
    logic [7:0]  dataOut;
    logic        dataAvailable;
    logic        dataRead;
    logic        framingError;
    logic        overrun;
    logic        clearErrors;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    uart_rx #(.CLOCK_SCALE_BITS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cyclesPerBit (cyclesPerBit),
        .rx           (rx),
        .dataOut      (dataOut),
        .dataAvailable(dataAvailable),
        .dataRead     (dataRead),
        .framingError (framingError),
        .overrun      (overrun),
        .clearErrors  (clearErrors),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: caller is at a negedge; each bit is held C cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        int c;
        c = int'(cyclesPerBit);
        rx = 1'b0;
        repeat (c) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (c) @(negedge clk);
        end
        rx = stop_v;
        repeat (c) @(negedge clk);
    endtask

    // Acknowledge any waiting byte and clear sticky flags (stimulus only).
    task automatic tidy();
        @(negedge clk);
        dataRead    = 1'b1;
        clearErrors = 1'b1;
        @(negedge clk);
        dataRead    = 1'b0;
        clearErrors = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        dataRead = 1'b0;
        clearErrors = 1'b0;
        cyclesPerBit = 16'd16;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dataOut, dataAvailable, framingError, overrun, busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_values: got dataOut=%h avail=%b fe=%b ov=%b busy=%b, required all zero",
                     dataOut, dataAvailable, framingError, overrun, busy);
        end
    endtask

    task automatic test_latency();
        int c, lat;
        cyclesPerBit = 16'd16;
        tidy();
        c = 16;
        lat = 2 + (c / 2) + 9 * c;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (lat) @(negedge clk);
                tests_run++;
                if (dataAvailable !== 1'b0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL latency_early: avail=%b busy=%b, required avail=0 busy=1", dataAvailable, busy);
                end
                @(negedge clk);
                tests_run++;
                if (dataAvailable !== 1'b1 || dataOut !== 8'hA5) begin
                    tests_failed++;
                    $display("FAIL latency_deliver: avail=%b dataOut=%h, required avail=1 dataOut=a5", dataAvailable, dataOut);
                end
                @(negedge clk);
                tests_run++;
                if (busy !== 1'b0 || framingError !== 1'b0 || overrun !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL latency_after: busy=%b fe=%b ov=%b, required all 0", busy, framingError, overrun);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes_a[3];
        logic [7:0] e;
        int waited;
        bytes_a = '{8'h00, 8'hFF, 8'h3C};
        cyclesPerBit = 16'd16;
        tidy();
        exp_q.delete();
        foreach (bytes_a[i]) exp_q.push_back(bytes_a[i]);
        fork
            foreach (bytes_a[i]) send_frame(bytes_a[i], 1'b1);
            begin
                for (int n = 0; n < 3; n++) begin
                    waited = 0;
                    while (dataAvailable !== 1'b1 && waited < 400) begin
                        @(negedge clk);
                        waited++;
                    end
                    tests_run++;
                    if (dataAvailable !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL b2b_timeout item %0d: avail=%b, required 1", n, dataAvailable);
                    end else begin
                        e = exp_q.pop_front();
                        tests_run++;
                        if (dataOut !== e) begin
                            tests_failed++;
                            $display("FAIL b2b_data item %0d: got %h, required %h", n, dataOut, e);
                        end
                        dataRead = 1'b1;
                        @(negedge clk);
                        dataRead = 1'b0;
                    end
                end
            end
        join
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_overrun: got %b, required 0", overrun);
        end
    endtask

    task automatic test_overrun();
        int lat;
        cyclesPerBit = 16'd16;
        tidy();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        tests_run++;
        if (dataOut !== 8'h22 || overrun !== 1'b1 || dataAvailable !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set: dataOut=%h ov=%b avail=%b, required 22/1/1", dataOut, overrun, dataAvailable);
        end
        clearErrors = 1'b1;
        @(negedge clk);
        clearErrors = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b, required 0", overrun);
        end
        dataRead = 1'b1;
        @(negedge clk);
        dataRead = 1'b0;
        tests_run++;
        if (dataAvailable !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_clear: avail=%b, required 0", dataAvailable);
        end
        send_frame(8'h33, 1'b1);
        lat = 2 + 8 + 9 * 16;
        // Acknowledge in exactly the cycle of the next delivery.
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (lat) @(negedge clk);
                dataRead = 1'b1;
                @(negedge clk);
                dataRead = 1'b0;
                tests_run++;
                if (dataAvailable !== 1'b1 || overrun !== 1'b0 || dataOut !== 8'h44) begin
                    tests_failed++;
                    $display("FAIL read_same_cycle: avail=%b ov=%b dataOut=%h, required 1/0/44",
                             dataAvailable, overrun, dataOut);
                end
            end
        join
    endtask

    task automatic test_framing();
        cyclesPerBit = 16'd16;
        tidy();
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        tests_run++;
        if (framingError !== 1'b1 || dataAvailable !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL framing_break: fe=%b avail=%b busy=%b, required 1/0/1", framingError, dataAvailable, busy);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL break_hold: busy=%b, required 1", busy);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_release: busy=%b, required 0", busy);
        end
        clearErrors = 1'b1;
        @(negedge clk);
        clearErrors = 1'b0;
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dataOut !== 8'h81 || dataAvailable !== 1'b1 || framingError !== 1'b0) begin
            tests_failed++;
            $display("FAIL framing_recover: dataOut=%h avail=%b fe=%b, required 81/1/0", dataOut, dataAvailable, framingError);
        end
    endtask

    // Relies on the state left by test_framing: 0x81 waiting, no errors.
    task automatic test_glitch();
        cyclesPerBit = 16'd16;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_busy_rise: busy=%b, required 1", busy);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy_fall: busy=%b, required 0", busy);
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (dataOut !== 8'h81 || dataAvailable !== 1'b1 || framingError !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_no_effect: dataOut=%h avail=%b fe=%b busy=%b, required 81/1/0/0",
                     dataOut, dataAvailable, framingError, busy);
        end
    endtask

    task automatic test_loopback_odd();
        logic [7:0] bytes_a[8];
        logic [7:0] e;
        int waited;
        cyclesPerBit = 16'd5;
        tidy();
        exp_q.delete();
        foreach (bytes_a[i]) begin
            bytes_a[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(bytes_a[i]);
        end
        fork
            foreach (bytes_a[i]) send_frame(bytes_a[i], 1'b1);
            begin
                for (int n = 0; n < 8; n++) begin
                    waited = 0;
                    while (dataAvailable !== 1'b1 && waited < 200) begin
                        @(negedge clk);
                        waited++;
                    end
                    tests_run++;
                    if (dataAvailable !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL loop_timeout item %0d: avail=%b, required 1", n, dataAvailable);
                    end else begin
                        e = exp_q.pop_front();
                        tests_run++;
                        if (dataOut !== e) begin
                            tests_failed++;
                            $display("FAIL loop_data item %0d: got %h, required %h", n, dataOut, e);
                        end
                        dataRead = 1'b1;
                        @(negedge clk);
                        dataRead = 1'b0;
                    end
                end
            end
        join
        tests_run++;
        if (overrun !== 1'b0 || framingError !== 1'b0) begin
            tests_failed++;
            $display("FAIL loop_flags: ov=%b fe=%b, required 0/0", overrun, framingError);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        cyclesPerBit = 16'd16;
        tidy();
        send_frame(8'h99, 1'b1);
        send_frame(8'h99, 1'b1);
        repeat (2) @(negedge clk);
        // Start a frame, reset while data bits are being received.
        d = 8'hC3;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({dataOut, dataAvailable, framingError, overrun, busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid_data: dataOut=%h avail=%b fe=%b ov=%b busy=%b, required all zero",
                     dataOut, dataAvailable, framingError, overrun, busy);
        end
        repeat (3) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dataOut !== 8'h7E || dataAvailable !== 1'b1 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_recover: dataOut=%h avail=%b ov=%b, required 7e/1/0", dataOut, dataAvailable, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_loopback_odd();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
